// File: rtl/adia_pkg.sv
// Shared definitions for the two-stage adiabatic logic pipeline:
// logic function encoding, power-clock phase indices and a one-hot helper.
package adia_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  localparam logic [1:0] PH_EVAL1   = 2'd0;
  localparam logic [1:0] PH_HOLD1   = 2'd1;
  localparam logic [1:0] PH_EVAL2   = 2'd2;
  localparam logic [1:0] PH_RECOVER = 2'd3;

  function automatic logic [3:0] phase_onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/adia_phase_gen.sv
// Four-phase power-clock generator: a free-running 2-bit phase index that
// stalls while enable is low, plus its one-hot decode.
module adia_phase_gen
  import adia_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [1:0] ph,
  output logic [3:0] phase
);

  // Step through EVAL1 -> HOLD1 -> EVAL2 -> RECOVER and wrap; hold when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= PH_EVAL1;
    end else if (enable) begin
      ph <= ph + 2'd1;
    end
  end

  assign phase = phase_onehot(ph);

endmodule

// File: rtl/adia_logic2_pipe.sv
// Two-stage adiabatic-style logic pipeline. Stage 1 evaluates the inverted
// logic function during EVAL1, stage 2 re-inverts it during EVAL2, so the
// output carries the true function. Operands enter only at EVAL1, giving at
// most one operation per four cycles; the output side uses valid/ready and
// may drain even while the power clock is frozen.
module adia_logic2_pipe
  import adia_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       phase,
  output logic [CNT_W-1:0] op_count
);

  logic [1:0]       ph;
  logic             s1_full;
  logic             s2_full;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] s2_data;
  logic [WIDTH-1:0] f_val;
  logic             accept;
  logic             pop;
  logic             xfer;

  adia_phase_gen u_phase_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .ph     (ph),
    .phase  (phase)
  );

  // Selected logic function of the current operands.
  always_comb begin
    f_val = '0;
    case (op_e'(op))
      OP_AND:  f_val = a & b;
      OP_OR:   f_val = a | b;
      OP_XOR:  f_val = a ^ b;
      OP_PASS: f_val = a;
      default: f_val = a;
    endcase
  end

  // rst_n gates in_ready so nothing is offered as accepted while reset is held.
  assign in_ready  = rst_n & enable & (ph == PH_EVAL1) & ~s1_full;
  assign accept    = in_valid & in_ready;
  assign pop       = s2_full & out_ready;
  assign xfer      = enable & (ph == PH_EVAL2) & s1_full & (~s2_full | pop);
  assign out_valid = s2_full;
  assign out_data  = s2_data;

  // Stage 1 captures the inverted function on accept and empties when it hands off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full <= 1'b0;
      s1_data <= '0;
    end else if (accept) begin
      s1_full <= 1'b1;
      s1_data <= ~f_val;
    end else if (xfer) begin
      s1_full <= 1'b0;
    end
  end

  // Stage 2 re-inverts stage 1; a transfer wins over a same-cycle pop so it stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_full <= 1'b0;
      s2_data <= '0;
    end else if (xfer) begin
      s2_full <= 1'b1;
      s2_data <= ~s1_data;
    end else if (pop) begin
      s2_full <= 1'b0;
    end
  end

  // Count completed output handshakes, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (pop && (op_count != '1)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_adia_logic2_pipe.sv
// Self-checking bench for adia_logic2_pipe: a negedge monitor scores every
// output handshake against a queue of expected results pushed at input
// handshakes, while directed sequences probe latency, stalls, clock freeze,
// asynchronous reset and counter saturation.
module tb_adia_logic2_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       phase;
  logic [CNT_W-1:0] op_count;

  int               check_count = 0;
  int               pass_count = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_count;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;

  adia_logic2_pipe #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .phase     (phase),
    .op_count  (op_count)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle index used to measure latency and acceptance spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [WIDTH-1:0] ref_logic(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return x;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
  endtask

  // Offer one operand pair and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                               input logic [1:0] oi, output int acc_cyc);
    a        = ai;
    b        = bi;
    op       = oi;
    in_valid = 1'b1;
    acc_cyc  = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) checkOutput("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Let the pipeline empty out, bounded.
  task automatic waitDrain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_count  = '0;
      hold_valid = 1'b0;
    end else begin
      if (hold_valid && out_valid) checkOutput("out_stable", out_data, hold_data);
      if (out_valid && exp_q.size() == 0) begin
        checkOutput("stray_out_valid", out_valid, 1'b0);
      end else if (out_valid && out_ready) begin
        checkOutput("out_data", out_data, exp_q.pop_front());
        checkOutput("op_count", op_count, exp_count);
        if (exp_count != '1) exp_count++;
      end
      if (in_ready) checkOutput("in_ready_phase", phase, 4'b0001);
      if (in_valid && in_ready) exp_q.push_back(ref_logic(a, b, op));
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
    end
  end

  // Directed sequence.
  initial begin
    int t0, t1, t2;
    rst_n     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 8'hF0;
    b         = 8'h3C;
    op        = 2'b00;

    // Reset state while held, even with an operand offered.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_phase", phase, 4'b0001);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, 8'h00);
    checkOutput("rst_op_count", op_count, 4'h0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Single AND operation: latency, result and counter.
    applyStimulus(8'hF0, 8'h3C, 2'b00, t0);
    t1 = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        t1 = cyc;
        break;
      end
    end
    checkOutput("latency", t1 - t0, 3);
    checkOutput("and_result", out_data, 8'h30);
    @(posedge clk);
    @(negedge clk);
    checkOutput("op_count_one", op_count, 4'h1);
    @(posedge clk);
    #1;

    // Back-to-back OR, XOR, PASS: one acceptance every four cycles.
    applyStimulus(8'hF0, 8'h3C, 2'b01, t0);
    applyStimulus(8'hF0, 8'h3C, 2'b10, t1);
    applyStimulus(8'hF0, 8'h3C, 2'b11, t2);
    checkOutput("spacing_1", t1 - t0, 4);
    checkOutput("spacing_2", t2 - t1, 4);
    waitDrain();

    // Downstream stall: two fill the pipe, a third is held off.
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 2'b01, t0);
    applyStimulus(8'hA5, 8'h5A, 2'b10, t1);
    a        = 8'h77;
    b        = 8'h0F;
    op       = 2'b00;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("held_off", in_ready, 1'b0);
    end
    checkOutput("stall_data", out_data, 8'h36);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    t2 = -1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (in_ready) begin
        t2 = cyc;
        break;
      end
    end
    if (t2 < 0) checkOutput("third_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitDrain();

    // Freeze the power clock at HOLD1 with both stages full; the output still drains.
    out_ready = 1'b0;
    applyStimulus(8'hC3, 8'h81, 2'b00, t0);
    applyStimulus(8'h0F, 8'hFF, 2'b10, t1);
    enable    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("frozen_phase", phase, 4'b0010);
      if (i > 0) checkOutput("no_transfer", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("resume_phase", phase, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    checkOutput("resume_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    waitDrain();

    // Asynchronous reset with both stages occupied.
    out_ready = 1'b0;
    applyStimulus(8'h55, 8'hAA, 2'b01, t0);
    applyStimulus(8'h3C, 8'hC3, 2'b00, t1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", out_valid, 1'b0);
    checkOutput("arst_out_data", out_data, 8'h00);
    checkOutput("arst_in_ready", in_ready, 1'b0);
    checkOutput("arst_phase", phase, 4'b0001);
    checkOutput("arst_op_count", op_count, 4'h0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("no_stale", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Seventeen handshakes saturate the 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)), t0);
    end
    waitDrain();
    @(negedge clk);
    checkOutput("op_count_sat", op_count, 4'hF);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/adia_logic2_pipe.md
ADIA_LOGIC2_PIPE -- requirements
Module: adia_logic2_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand and result bit width (1..64).
REQ-002 SHALL provide parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  power-clock run enable; 0 freezes the phase counter and the internal stage transfers.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  operand pair accepted when in_valid and in_ready are both 1.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 op  input  2  function: 00 AND, 01 OR, 10 XOR, 11 pass-A.
REQ-010 out_valid  output  1  result held in stage 2.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  WIDTH  result.
REQ-013 phase  output  4  one-hot power-clock phase: bit0 EVAL1, bit1 HOLD1, bit2 EVAL2, bit3 RECOVER.
REQ-014 op_count  output  CNT_W  number of completed output handshakes, saturating.

Function
REQ-015 Phase counter ph SHALL advance 0->1->2->3->0 once per cycle while enable=1 and SHALL hold its value while enable=0; phase = one-hot(ph).
REQ-016 in_ready SHALL be 1 only when enable=1, ph=0 and stage 1 is empty.
REQ-017 On input handshake, stage 1 SHALL store the inverted function ~f(a,b,op) and set s1_full, matching the inverting first adiabatic stage.
REQ-018 In a cycle with enable=1, ph=2 and s1_full, stage 1 SHALL transfer to stage 2 if stage 2 is empty or popping in that cycle; stage 2 SHALL store the inversion of stage 1, so out_data = f(a,b,op).
REQ-019 A blocked transfer at ph=2 SHALL retry at the next ph=2; no data SHALL be lost or duplicated.
REQ-020 out_valid = s2_full; pop on out_valid and out_ready in any phase, including while enable=0.
REQ-021 Unstalled latency SHALL be 3 cycles: handshake in cycle t (ph=0) gives out_valid in cycle t+3.
REQ-022 Throughput SHALL be at most one operation per 4 cycles.
REQ-023 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 op_count SHALL increment on each output handshake and SHALL hold at 2^CNT_W-1.
REQ-025 Simultaneous pop and transfer in the same cycle SHALL leave s2_full=1 holding the new data.

Reset
REQ-026 While rst_n=0: ph=0 (phase=0001), s1_full=0, s2_full=0, stage data=0, out_data=0, out_valid=0, in_ready=0, op_count=0.
REQ-027 Assertion mid-operation SHALL discard all in-flight data immediately.
REQ-028 After rst_n deasserts, in_ready SHALL go to 1 in the first cycle in which enable=1.

Structure
REQ-029 Shared package adia_pkg SHALL hold the op enum (OP_AND, OP_OR, OP_XOR, OP_PASS) and the phase index constants PH_EVAL1..PH_RECOVER.
REQ-030 The phase counter and one-hot decode SHALL be the sub-module adia_phase_gen (ports clk, rst_n, enable, ph, phase); the pipeline stays in the top module.

Verification
REQ-031 WIDTH=8, a=F0, b=3C, op=00 accepted at ph=0, out_ready=1 -> out_valid 3 cycles later, out_data=30, op_count=1.
REQ-032 Back-to-back stream of op=01, 10, 11 with out_ready=1 -> results 3C|F0=FC, 3C^F0=CC, F0 for a=F0, b=3C; one result every 4 cycles; in_ready high only at ph=0.
REQ-033 out_ready=0 for 12 cycles with 3 inputs offered -> 2 accepted (stage 1 and stage 2 full), third held off; out_data constant; after release, all results arrive in order.
REQ-034 enable=0 at ph=1 for 5 cycles -> phase frozen at 0010, no transfer; out pop still works; resume continues at ph=2.
REQ-035 rst_n pulsed low with s1_full and s2_full set -> outputs zero within the same cycle; no stale result after release.
REQ-036 CNT_W=4, 17 completed handshakes -> op_count saturates at F.
